lfsr_checker: RTL



---
 rtl/lfsr_pkg.sv | 25 ++
 rtl/lfsr_checker_if.sv | 26 ++
 rtl/lfsr_chk_window_mon.sv | 45 ++++
 rtl/lfsr_checker.sv | 133 +++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 32-bit XNOR noise LFSR generator and its checker.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package lfsr_pkg;

    localparam int LFSR_W = 32;

    // Feedback taps (bit indices into the state register)
    localparam int TAP_A = 31;
    localparam int TAP_B = 21;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    // XNOR feedback: the bit the generator shifts into the LSB next
    function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] s);
        return ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]);
    endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Bundle of serial-bit input and lock/error status outputs of lfsr_checker.
// Latency: n/a (wires only).
// Backpressure: none; bit_valid qualifies bit_in, the checker always accepts.
interface lfsr_checker_if #(
    parameter int ERR_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             clear_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state;

    // Stream source / status observer side
    modport master (
        output bit_in, bit_valid, clear_err,
        input  locked, err_pulse, err_count, state
    );

    // Checker side
    modport slave (
        input  bit_in, bit_valid, clear_err,
        output locked, err_pulse, err_count, state
    );
endinterface

// File: rtl/lfsr_chk_window_mon.sv
// Counts valid locked bits in fixed windows and the mismatches inside each one.
// Latency: o_loss is combinational on the bit that would reach the threshold.
// Backpressure: none; only advances on i_valid, i_clear zeroes both counters.
module lfsr_chk_window_mon #(
    parameter int WINDOW      = 256,
    parameter int LOSS_THRESH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic i_mismatch,
    input  logic i_clear,
    output logic o_loss
);
    localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
    localparam logic [15:0] ERR_LAST = 16'(LOSS_THRESH - 1);

    logic [15:0] r_win_cnt;
    logic [15:0] r_win_err;
    logic        w_win_last;

    assign w_win_last = (r_win_cnt == WIN_LAST);
    // The mismatch that would make win_err reach the threshold is the loss event
    assign o_loss     = i_valid && i_mismatch && (r_win_err == ERR_LAST);

    // Window position and per-window error tally; restart after the last bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else if (i_clear || o_loss) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else if (i_valid) begin
            if (w_win_last) begin
                r_win_cnt <= '0;
                r_win_err <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + 16'd1;
                r_win_err <= r_win_err + {15'd0, i_mismatch};
            end
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 32-bit XNOR LFSR bit stream (lock, error strobe, count).
// Latency: locked/err_pulse/err_count/state are registered, visible the cycle after the sampling edge.
// Backpressure: none; bits are taken whenever bit_valid is high. Build option LFSR_CHK_ERR_SAT_EN makes err_count saturate.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_MATCHES = 64,
    parameter int WINDOW       = 256,
    parameter int LOSS_THRESH  = 8,
    parameter int ERR_W        = 16
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_checker_if.slave bus
);
    localparam logic [7:0] MATCH_LAST = 8'(LOCK_MATCHES - 1);
    localparam logic [5:0] FILL_FULL  = 6'(LFSR_W);

    logic [LFSR_W-1:0] r_sreg;
    logic [5:0]        r_fill_cnt;
    logic [7:0]        r_match_cnt;
    chk_state_e        r_state;
    logic              r_locked;
    logic              r_err_pulse;
    logic [ERR_W-1:0]  r_err_count;

    logic              w_pred;
    logic              w_mismatch;
    logic              w_new_bit;
    logic [LFSR_W-1:0] w_sreg_nxt;
    logic              w_win_valid;
    logic              w_win_clear;
    logic              w_loss;
    logic              w_err;
    logic [ERR_W-1:0]  w_err_count_inc;

    assign w_pred      = lfsr_next_bit(r_sreg);
    assign w_mismatch  = (bus.bit_in != w_pred);
    // Flywheel when locked: received errors never reach the local state copy
    assign w_new_bit   = (r_state == LOCKED) ? w_pred : bus.bit_in;
    assign w_sreg_nxt  = {r_sreg[LFSR_W-2:0], w_new_bit};
    assign w_win_valid = bus.bit_valid && (r_state == LOCKED);
    assign w_win_clear = (r_state != LOCKED);
    assign w_err       = w_win_valid && w_mismatch;

`ifdef LFSR_CHK_ERR_SAT_EN
    assign w_err_count_inc = (&r_err_count) ? r_err_count : r_err_count + 1'b1;
`else
    assign w_err_count_inc = r_err_count + 1'b1;
`endif

    lfsr_chk_window_mon #(
        .WINDOW      (WINDOW),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_win_mon (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (w_win_valid),
        .i_mismatch (w_mismatch),
        .i_clear    (w_win_clear),
        .o_loss     (w_loss)
    );

    // Acquisition FSM, local state copy and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sreg      <= '0;
            r_fill_cnt  <= '0;
            r_match_cnt <= '0;
            r_state     <= SEARCH;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_err;
            // Clear has priority over a simultaneous counted error
            if (bus.clear_err) begin
                r_err_count <= '0;
            end else if (w_err) begin
                r_err_count <= w_err_count_inc;
            end

            if (bus.bit_valid) begin
                r_sreg <= w_sreg_nxt;
                case (r_state)
                    SEARCH: begin
                        if (r_fill_cnt != FILL_FULL) begin
                            r_fill_cnt <= r_fill_cnt + 6'd1;
                        end
                        // All-ones is the XNOR lockup state: never verify from it
                        if ((r_fill_cnt >= FILL_FULL - 6'd1) && (w_sreg_nxt != '1)) begin
                            r_state     <= VERIFY;
                            r_match_cnt <= '0;
                        end
                    end
                    VERIFY: begin
                        if (w_mismatch) begin
                            r_state     <= SEARCH;
                            r_fill_cnt  <= '0;
                            r_match_cnt <= '0;
                        end else begin
                            r_match_cnt <= r_match_cnt + 8'd1;
                            if (r_match_cnt == MATCH_LAST) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (w_loss) begin
                            r_state     <= SEARCH;
                            r_locked    <= 1'b0;
                            r_fill_cnt  <= '0;
                            r_match_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state     <= SEARCH;
                        r_locked    <= 1'b0;
                        r_fill_cnt  <= '0;
                        r_match_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;
    assign bus.state     = r_state;

endmodule
